// File: rtl/prbs7_gen32.sv
// 32-bit-per-clock PRBS7 (x^7+x^6+1) source with seeding, gated output and
// single/periodic bit-error injection that never disturbs the LFSR state.
module prbs7_gen32 #(
  parameter logic [6:0]  SEED       = 7'h7F,
  parameter int unsigned ERR_PERIOD = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load_seed,
  input  logic [6:0]  seed_in,
  input  logic        inj_err,
  input  logic [4:0]  inj_bit,
  input  logic        per_inj_en,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic [15:0] inj_count
);

  localparam logic [6:0]  SEED_EFF = (SEED == 7'd0) ? 7'h7F : SEED;
  localparam logic [15:0] PER_LAST = 16'(ERR_PERIOD - 1);

  logic [6:0]  state;
  logic [15:0] per_cnt;
  logic        pending;

  logic [6:0]  c;
  logic [31:0] w;
  logic [31:0] mask;
  logic [6:0]  seed_eff;
  logic        advance;
  logic        per_hit;
  logic        corrupt;

  // Unrolled 32-step serial LFSR; bit 0 of w is the oldest bit in time.
  always_comb begin
    c = state;
    w = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      w[i] = c[1] ^ c[0];
      c    = {w[i], c[6:1]};
    end
  end

  always_comb begin
    seed_eff = (seed_in == 7'd0) ? 7'h7F : seed_in;
    advance  = en & ~load_seed;
    per_hit  = per_inj_en & (per_cnt == PER_LAST);
    corrupt  = advance & (pending | inj_err | per_hit);
    mask     = corrupt ? (32'd1 << inj_bit) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEED_EFF;
      per_cnt    <= '0;
      pending    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      inj_count  <= '0;
    end else begin
      dout_valid <= advance;
      if (load_seed) begin
        state <= seed_eff;
      end else if (en) begin
        state <= w[31:25];
        dout  <= w ^ mask;
      end

      if (advance)
        pending <= 1'b0;
      else if (inj_err)
        pending <= 1'b1;

      if (load_seed || !per_inj_en)
        per_cnt <= '0;
      else if (en)
        per_cnt <= per_hit ? '0 : per_cnt + 16'd1;

      if (corrupt && inj_count != '1)
        inj_count <= inj_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_prbs7_gen32.sv
// Directed bench for prbs7_gen32; expected words come from a serial bit-stream
// model of the PRBS7 recurrence b[n+7] = b[n+1] ^ b[n].
module tb_prbs7_gen32;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load_seed;
  logic [6:0]  seed_in;
  logic        inj_err;
  logic [4:0]  inj_bit;
  logic        per_inj_en;
  logic [31:0] dout;
  logic        dout_valid;
  logic [15:0] inj_count;

  int vecs = 0;
  int errs = 0;
  logic sb [0:126];

  prbs7_gen32 #(.SEED(7'h7F), .ERR_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load_seed(load_seed), .seed_in(seed_in),
    .inj_err(inj_err), .inj_bit(inj_bit), .per_inj_en(per_inj_en),
    .dout(dout), .dout_valid(dout_valid), .inj_count(inj_count)
  );

  always #12.5 clk = ~clk;

  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] r;
    int base;
    base = 7 + 32 * (k % 127);
    for (int i = 0; i < 32; i++) r[i] = sb[(base + i) % 127];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int wk;
    logic [31:0] held;
    logic        en_pat [0:5];

    for (int j = 0; j < 7; j++) sb[j] = 1'b1;
    for (int j = 7; j < 127; j++) sb[j] = sb[j-6] ^ sb[j-7];
    en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; en = 1'b0; load_seed = 1'b0; seed_in = '0;
    inj_err = 1'b0; inj_bit = '0; per_inj_en = 1'b0;
    #3;
    chk("rst_dout", dout, 32'h0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_injcnt", {16'd0, inj_count}, 32'd0);
    do_reset();

    // Continuous run: hand-computed word 0, then model over 300 words.
    en = 1'b1;
    cyc();
    chk("word0_hand", dout, 32'h4F14_3040);
    chk("word0_valid", {31'd0, dout_valid}, 32'd1);
    for (int k = 1; k < 300; k++) begin
      cyc();
      chk($sformatf("cont_w%0d", k), dout, exp_word(k));
    end
    wk = 300;

    // Gated enable: valid follows en by one cycle; dout holds across gaps.
    held = exp_word(wk - 1);
    for (int j = 0; j < 6; j++) begin
      en = en_pat[j];
      cyc();
      if (en_pat[j]) begin
        held = exp_word(wk);
        wk++;
      end
      chk($sformatf("gate_valid%0d", j), {31'd0, dout_valid}, {31'd0, en_pat[j]});
      chk($sformatf("gate_dout%0d", j), dout, held);
    end

    // Manual injection requested while idle, re-requested while pending.
    en = 1'b0; inj_bit = 5'd5; inj_err = 1'b1;
    cyc();
    cyc();
    inj_err = 1'b0; en = 1'b1;
    cyc();
    chk("inj5_word", dout, exp_word(wk) ^ 32'h0000_0020);
    wk++;
    cyc();
    chk("inj5_next_clean", dout, exp_word(wk));
    wk++;
    chk("inj5_count", {16'd0, inj_count}, 32'd1);

    // Injection in the same cycle as a consuming en; state must stay clean.
    inj_bit = 5'd28; inj_err = 1'b1;
    cyc();
    chk("inj28_word", dout, exp_word(wk) ^ 32'h1000_0000);
    wk++;
    inj_err = 1'b0;
    cyc();
    chk("inj28_next_clean", dout, exp_word(wk));
    wk++;
    cyc();
    chk("inj28_next2_clean", dout, exp_word(wk));
    chk("inj28_count", {16'd0, inj_count}, 32'd2);

    // Seed load of 0 maps to 7'h7F and restarts the sequence; en ignored.
    load_seed = 1'b1; seed_in = 7'd0;
    cyc();
    chk("load_valid", {31'd0, dout_valid}, 32'd0);
    load_seed = 1'b0;
    cyc();
    chk("load_word0", dout, 32'h4F14_3040);
    cyc();
    chk("load_word1", dout, exp_word(1));

    // Periodic injection with period 4, plus a coincident manual request.
    en = 1'b0;
    do_reset();
    per_inj_en = 1'b1; en = 1'b1; inj_bit = 5'd9;
    for (int j = 0; j < 40; j++) begin
      inj_err = (j == 7);
      cyc();
      chk($sformatf("per_w%0d", j), dout,
          exp_word(j) ^ (((j % 4) == 3) ? 32'h0000_0200 : 32'h0));
    end
    inj_err = 1'b0; per_inj_en = 1'b0;
    chk("per_count", {16'd0, inj_count}, 32'd10);

    // Asynchronous reset mid-burst.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_dout", dout, 32'h0);
    chk("async_valid", {31'd0, dout_valid}, 32'd0);
    chk("async_injcnt", {16'd0, inj_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("post_rst_word0", dout, 32'h4F14_3040);
    cyc();
    chk("post_rst_word1", dout, exp_word(1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
